// File: rtl/fetch_queue_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fetch_queue_pkg : shared defaults and entry layout for fetch_queue   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package fetch_queue_pkg;

   localparam int A_DEFAULT     = 10;
   localparam int W_DEFAULT     = 9;
   localparam int DEPTH_DEFAULT = 4;

   typedef struct packed {
      logic [W_DEFAULT-1:0] inst;
      logic [A_DEFAULT-1:0] pc;
   } entry_t;

   // Width able to hold the values 0..depth inclusive.
   function automatic int count_width(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_queue_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fetch_queue_if : PC / ROM / decode-side signals of the fetch queue   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface fetch_queue_if
   import fetch_queue_pkg::*;
#(
   parameter int A     = A_DEFAULT,
   parameter int W     = W_DEFAULT,
   parameter int DEPTH = DEPTH_DEFAULT
);
   localparam int CW = count_width(DEPTH);

   logic [A-1:0]  FetchAddr;
   logic          FetchEn;
   logic          Flush;
   logic [W-1:0]  RomData;
   logic          OutReady;
   logic [A-1:0]  RomAddr;
   logic          RomRd;
   logic          FetchHold;
   logic          OutValid;
   logic [W-1:0]  OutInst;
   logic [A-1:0]  OutPc;
   logic [CW-1:0] Count;

   modport master (
      input  FetchAddr, FetchEn, Flush, RomData, OutReady,
      output RomAddr, RomRd, FetchHold, OutValid, OutInst, OutPc, Count
   );

   modport slave (
      output FetchAddr, FetchEn, Flush, RomData, OutReady,
      input  RomAddr, RomRd, FetchHold, OutValid, OutInst, OutPc, Count
   );

endinterface
`default_nettype wire

// File: rtl/fq_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fq_fifo : power-of-two FIFO with synchronous clear, unreset storage  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module fq_fifo #(
   parameter int  DEPTH   = 4,
   parameter type ENTRY_T = fetch_queue_pkg::entry_t
) (
   input  wire logic                       clk,
   input  wire logic                       reset_n,
   input  wire logic                       clear,
   input  wire logic                       push,
   input  wire logic                       pop,
   input  wire ENTRY_T                     din,
   output      ENTRY_T                     dout,
   output      logic [$clog2(DEPTH+1)-1:0] count
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   ENTRY_T        mem [DEPTH];
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr;
   logic          do_pop;

   // Popping an empty FIFO is a no-op.
   assign do_pop = pop && (count != '0);

   always_ff @(posedge clk) begin
      if (!reset_n || clear) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push)   wr_ptr <= wr_ptr + PW'(1);
         if (do_pop) rd_ptr <= rd_ptr + PW'(1);
         if (push && !do_pop)      count <= count + CW'(1);
         else if (!push && do_pop) count <= count - CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset_n && !clear && push) mem[wr_ptr] <= din;
   end

   assign dout = mem[rd_ptr];

   a_no_overflow : assert property (@(posedge clk) disable iff (!reset_n)
      !(push && !clear && count == CW'(DEPTH)));

endmodule
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fetch_queue : instruction prefetch buffer between PC, ROM and decode |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module fetch_queue
   import fetch_queue_pkg::*;
#(
   parameter int A     = A_DEFAULT,
   parameter int W     = W_DEFAULT,
   parameter int DEPTH = DEPTH_DEFAULT
) (
   input  wire logic        Clk,
   input  wire logic        Reset_n,
   fetch_queue_if.master    bus
);
   localparam int CW = count_width(DEPTH);

   typedef struct packed {
      logic [W-1:0] inst;
      logic [A-1:0] pc;
   } fq_entry_t;

   logic          in_flight;
   logic [A-1:0]  in_flight_pc;
   logic          issue;
   logic          push;
   logic          pop;
   logic [CW:0]   occupancy;
   logic [CW-1:0] count;
   fq_entry_t     push_entry;
   fq_entry_t     head;

   // Hold counts the in-flight read as occupied; a same-cycle pop gives no credit.
   assign occupancy     = {1'b0, count} + {{CW{1'b0}}, in_flight};
   assign bus.FetchHold = Reset_n && (occupancy == (CW+1)'(DEPTH));
   assign issue         = bus.FetchEn && !bus.FetchHold && !bus.Flush;
   assign bus.RomRd     = issue;
   assign bus.RomAddr   = bus.FetchAddr;

   assign bus.OutValid  = Reset_n && (count != '0);
   assign pop           = bus.OutValid && bus.OutReady;
   assign push          = in_flight && !bus.Flush;
   assign push_entry    = '{inst: bus.RomData, pc: in_flight_pc};

   always_ff @(posedge Clk) begin
      if (!Reset_n) in_flight <= 1'b0;
      else          in_flight <= issue;
   end

   always_ff @(posedge Clk) begin
      if (issue) in_flight_pc <= bus.FetchAddr;
   end

   fq_fifo #(
      .DEPTH   (DEPTH),
      .ENTRY_T (fq_entry_t)
   ) u_fifo (
      .clk     (Clk),
      .reset_n (Reset_n),
      .clear   (bus.Flush),
      .push    (push),
      .pop     (pop),
      .din     (push_entry),
      .dout    (head),
      .count   (count)
   );

   assign bus.OutInst = head.inst;
   assign bus.OutPc   = head.pc;
   assign bus.Count   = count;

endmodule
`default_nettype wire
